// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  // Width of the sclk toggle counter, which indexes 2*data_w toggles.
  function automatic int bit_cnt_w(input int data_w);
    return (data_w < 2) ? 1 : $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for SCLK: emits a registered one-cycle half_tick every
// CLK_DIV enabled cycles, restarting from zero whenever clear is raised.
module spi_clk_div
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic half_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 while enabled and flag each wrap for one cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt       <= '0;
      half_tick <= 1'b0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt       <= '0;
        half_tick <= 1'b1;
      end else begin
        cnt       <= cnt + CW'(1);
        half_tick <= 1'b0;
      end
    end else begin
      half_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: one word per accepted start, with
// per-transfer CPOL/CPHA and bit order, and a busy/done/err handshake.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 3,
  parameter int SS_W    = 2,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SS_W-1:0]   slave_select,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = bit_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_TOG = CNT_W'(2 * DATA_W - 1);

  state_t            state;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              half_tick;
  logic              ss_ok;
  logic              accept;
  logic [CNT_W-1:0]  tog_idx;
  logic              sample_edge;
  logic              shift_edge;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != IDLE),
    .clear    (accept),
    .half_tick(half_tick)
  );

  // Decode start acceptance and classify the next sclk toggle as sample or shift
  always_comb begin
    ss_ok       = (int'(slave_select) < NUM_CS);
    accept      = (state == IDLE) && start && ss_ok;
    tog_idx     = (state == LEAD) ? '0 : bit_cnt + CNT_W'(1);
    sample_edge = (tog_idx[0] == cpha_q);
    shift_edge  = !sample_edge && !(!cpha_q && (tog_idx == LAST_TOG));
  end

  // Transfer sequencer: owns every output pin, the mode latches and both shift registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      cs_n    <= '1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          cs_n <= '1;
          if (start && !ss_ok) begin
            err <= 1'b1;
          end else if (accept) begin
            state   <= LEAD;
            busy    <= 1'b1;
            cs_n    <= ~(NUM_CS'(1) << slave_select);
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            rx_sr   <= '0;
            bit_cnt <= '0;
            if (!cpha) begin
              mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
              tx_sr <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end else begin
              tx_sr <= tx_data;
            end
          end
        end
        LEAD, SHIFT: begin
          if (half_tick) begin
            if ((state == SHIFT) && (bit_cnt == LAST_TOG)) begin
              state <= TRAIL;
            end else begin
              state   <= SHIFT;
              sclk    <= ~sclk;
              bit_cnt <= tog_idx;
              if (sample_edge) begin
                rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
              end
              if (shift_edge) begin
                mosi  <= lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
                tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
              end
            end
          end
        end
        TRAIL: begin
          if (half_tick) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cs_n    <= '1;
            rx_data <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: three configurations share the
// stimulus pins, a pin-level slave model answers on miso and records mosi.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = '0;
  logic [1:0]  slave_select = '0;
  logic [15:0] tx_data = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic        miso = 1'b0;

  wire [7:0]  rx0;
  wire [7:0]  rx1;
  wire [15:0] rx2;
  wire [2:0]  busy_v;
  wire [2:0]  done_v;
  wire [2:0]  err_v;
  wire [2:0]  sclk_v;
  wire [2:0]  mosi_v;
  wire [2:0]  cs0;
  wire [2:0]  cs1;
  wire [3:0]  cs2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel = 0;
  int acc = 0;
  int exp_lat = 0;

  logic [15:0] c_rx;
  logic [3:0]  c_cs;
  logic        c_busy, c_done, c_err, c_sclk, c_mosi;

  int          m_dw = 8;
  logic        m_cpha = 1'b0;
  logic        m_lsb = 1'b0;
  logic [15:0] m_word = '0;
  logic [15:0] m_tx = '0;
  logic [3:0]  exp_cs = 4'hF;

  logic        mon_act = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        cs_changed = 1'b0;
  logic [3:0]  mon_cs = 4'hF;
  logic [15:0] slv_rx = '0;
  int          tog = 0;
  int          ri = 0;
  int          si = 0;

  spi_master_param u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .slave_select(slave_select),
    .tx_data(tx_data[7:0]), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .rx_data(rx0), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .sclk(sclk_v[0]), .cs_n(cs0), .mosi(mosi_v[0]), .miso(miso)
  );

  spi_master_param #(.DATA_W(8), .NUM_CS(3), .SS_W(2), .CLK_DIV(4)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .slave_select(slave_select),
    .tx_data(tx_data[7:0]), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .rx_data(rx1), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .sclk(sclk_v[1]), .cs_n(cs1), .mosi(mosi_v[1]), .miso(miso)
  );

  spi_master_param #(.DATA_W(16), .NUM_CS(4), .SS_W(2), .CLK_DIV(2)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .slave_select(slave_select),
    .tx_data(tx_data), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .rx_data(rx2), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]),
    .sclk(sclk_v[2]), .cs_n(cs2), .mosi(mosi_v[2]), .miso(miso)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Posedge counter used to time done relative to the accepting edge
  always @(posedge clk) cyc <= cyc + 1;

  // View of whichever instance the current step is exercising
  always_comb begin
    c_rx = {8'h00, rx0}; c_cs = {1'b1, cs0};
    c_busy = busy_v[0]; c_done = done_v[0]; c_err = err_v[0];
    c_sclk = sclk_v[0]; c_mosi = mosi_v[0];
    if (sel == 1) begin
      c_rx = {8'h00, rx1}; c_cs = {1'b1, cs1};
      c_busy = busy_v[1]; c_done = done_v[1]; c_err = err_v[1];
      c_sclk = sclk_v[1]; c_mosi = mosi_v[1];
    end else if (sel == 2) begin
      c_rx = rx2; c_cs = cs2;
      c_busy = busy_v[2]; c_done = done_v[2]; c_err = err_v[2];
      c_sclk = sclk_v[2]; c_mosi = mosi_v[2];
    end
  end

  function automatic logic sbit(input int i);
    return m_lsb ? m_word[i] : m_word[m_dw-1-i];
  endfunction

  // Slave model: reacts to sclk edges while selected, captures mosi, drives miso
  always @(negedge clk) begin
    if (reset) begin
      mon_act = 1'b0;
    end else if (!mon_act && (c_cs != 4'hF)) begin
      mon_act = 1'b1; tog = 0; ri = 0; si = 0; slv_rx = '0;
      mon_cs = c_cs; cs_changed = 1'b0;
      if (!m_cpha) begin
        miso = sbit(0);
        si = 1;
      end
    end else if (mon_act) begin
      if (c_cs == 4'hF) begin
        mon_act = 1'b0;
      end else begin
        if (c_cs != mon_cs) cs_changed = 1'b1;
        if (c_sclk != prev_sclk) begin
          tog = tog + 1;
          if (((tog % 2) == 1) == !m_cpha) begin
            if (ri < m_dw) slv_rx[m_lsb ? ri : m_dw-1-ri] = c_mosi;
            ri = ri + 1;
          end else if (si < m_dw) begin
            miso = sbit(si);
            si = si + 1;
          end
        end
      end
    end
    prev_sclk = c_sclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: set up pins and reference, pulse start for one edge
  task automatic applyStimulus(input int s, input logic [1:0] ss, input logic [15:0] tx,
                               input logic pol, input logic pha, input logic lsb,
                               input logic [15:0] sw);
    int kdiv;
    sel = s;
    slave_select = ss; tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb;
    m_dw = (s == 2) ? 16 : 8;
    kdiv = (s == 0) ? 1 : ((s == 1) ? 4 : 2);
    m_word = (m_dw == 16) ? sw : (sw & 16'h00FF);
    m_tx = (m_dw == 16) ? tx : (tx & 16'h00FF);
    m_cpha = pha; m_lsb = lsb;
    exp_cs = 4'hF & ~(4'b0001 << ss);
    exp_lat = (2 * m_dw + 2) * kdiv + 1;
    start_v = 3'b001 << s;
    acc = cyc + 1;
    @(negedge clk);
    start_v = '0;
  endtask

  // Wait (bounded) for done and check the whole transfer; returns in the done cycle
  task automatic finishXfer(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (c_done) got = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, got, 1);
    checkOutput({tag, "_latency"}, cyc - acc, exp_lat);
    checkOutput({tag, "_rx_data"}, c_rx, m_word);
    checkOutput({tag, "_slave_rx"}, slv_rx, m_tx);
    checkOutput({tag, "_toggles"}, tog, 2 * m_dw);
    checkOutput({tag, "_cs_n"}, mon_cs, exp_cs);
    checkOutput({tag, "_cs_stable"}, cs_changed, 0);
    checkOutput({tag, "_busy_done"}, c_busy, 0);
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, c_done, 0);
    checkOutput({tag, "_idle_cs"}, c_cs, 4'hF);
    checkOutput({tag, "_idle_busy"}, c_busy, 0);
  endtask

  initial begin
    int dcount;
    int bcount;
    int s;
    int ss;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", c_cs, 4'hF);
    checkOutput("rst_sclk", c_sclk, 0);
    checkOutput("rst_mosi", c_mosi, 0);
    checkOutput("rst_busy", c_busy, 0);
    checkOutput("rst_done", c_done, 0);
    checkOutput("rst_err", c_err, 0);
    checkOutput("rst_rx", c_rx, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, LSB first, divider 1, select 0
    applyStimulus(0, 2'd0, 16'h00D6, 1'b0, 1'b0, 1'b1, 16'h00D3);
    checkOutput("m0_busy", c_busy, 1);
    finishXfer("m0");
    idleCheck("m0");

    // Mode 3, MSB first, divider 4, select 2; sclk idles high
    sel = 1; cpol = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("m3_idle_sclk", c_sclk, 1);
    applyStimulus(1, 2'd2, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h003C);
    finishXfer("m3");
    idleCheck("m3");
    checkOutput("m3_end_sclk", c_sclk, 1);
    cpol = 1'b0;
    repeat (2) @(negedge clk);

    // 16-bit word, mode 1, divider 2, select 3
    applyStimulus(2, 2'd3, 16'h1234, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    finishXfer("w16");
    idleCheck("w16");

    // Randomised transfers across all three configurations
    for (int n = 0; n < 8; n++) begin
      s = $urandom_range(0, 2);
      ss = $urandom_range(0, (s == 2) ? 3 : 2);
      applyStimulus(s, 2'(ss), 16'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 16'($urandom));
      finishXfer("rand");
      idleCheck("rand");
    end

    // Start while busy is ignored; start in the done cycle is accepted
    applyStimulus(0, 2'd0, 16'h00C3, 1'b0, 1'b1, 1'b1, 16'h0081);
    repeat (4) @(negedge clk);
    slave_select = 2'd2; tx_data = 16'h00FF; cpha = 1'b0; lsb_first = 1'b0;
    start_v = 3'b001;
    @(negedge clk);
    start_v = '0;
    checkOutput("mid_busy", c_busy, 1);
    checkOutput("mid_err", c_err, 0);
    checkOutput("mid_cs", c_cs, 4'hE);
    finishXfer("b2b_first");
    applyStimulus(0, 2'd1, 16'h0036, 1'b0, 1'b0, 1'b0, 16'h007E);
    checkOutput("b2b_cs", c_cs, 4'hD);
    checkOutput("b2b_busy", c_busy, 1);
    finishXfer("b2b_second");
    idleCheck("b2b");

    // Out-of-range select raises err only
    sel = 0; cpol = 1'b0;
    repeat (2) @(negedge clk);
    slave_select = 2'd3; start_v = 3'b001;
    @(negedge clk);
    start_v = '0;
    checkOutput("bad_err", c_err, 1);
    checkOutput("bad_busy", c_busy, 0);
    checkOutput("bad_cs", c_cs, 4'hF);
    checkOutput("bad_sclk", c_sclk, 0);
    @(negedge clk);
    checkOutput("bad_err_pulse", c_err, 0);
    dcount = 0; bcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (c_done) dcount++;
      if (c_busy) bcount++;
    end
    checkOutput("bad_no_done", dcount, 0);
    checkOutput("bad_no_busy", bcount, 0);

    // Reset seven edges into a transfer, then a clean transfer
    applyStimulus(0, 2'd1, 16'h005A, 1'b1, 1'b0, 1'b0, 16'h0099);
    while (cyc < acc + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mrst_cs", c_cs, 4'hF);
    checkOutput("mrst_sclk", c_sclk, 0);
    checkOutput("mrst_busy", c_busy, 0);
    checkOutput("mrst_rx", c_rx, 0);
    checkOutput("mrst_done", c_done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(0, 2'd2, 16'h0069, 1'b0, 1'b0, 1'b1, 16'h00E4);
    finishXfer("post_rst");
    idleCheck("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
